spi_bus_arbiter: RTL and testbench

Shares the single board SPI bus (SCLK/MOSI/MISO) between NUM_REQ on-board requesters: the FPGA config path, the FIFO readout, the EEPROM and the ADT7301 temperature sensor. The block runs a round-robin grant, drives the winner's active-low chip select and executes one mode-0, MSB-first transfer of DATA_W bits. It sits between the requester logic and the SPI pin mux. It is the only block that drives SCLK and any chip select.

---
 rtl/spi_bus_arbiter_if.sv | 27 ++
 rtl/spi_bus_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_spi_bus_arbiter.sv | 323 ++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_bus_arbiter_if.sv
// Requester-side and SPI pin-side signals of the shared SPI bus arbiter.
// The master modport is the arbiter; slave is the requesters/pin mux side.
interface spi_bus_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int DATA_W  = 16
);
  logic [NUM_REQ-1:0]        req;
  logic [NUM_REQ*DATA_W-1:0] tx_data;
  logic [NUM_REQ-1:0]        gnt;
  logic [NUM_REQ-1:0]        done;
  logic [DATA_W-1:0]         rx_data;
  logic                      busy;
  logic                      spi_sclk;
  logic                      spi_mosi;
  logic                      spi_miso;
  logic [NUM_REQ-1:0]        spi_cs_n;

  modport master (
    input  req, tx_data, spi_miso,
    output gnt, done, rx_data, busy, spi_sclk, spi_mosi, spi_cs_n
  );

  modport slave (
    output req, tx_data, spi_miso,
    input  gnt, done, rx_data, busy, spi_sclk, spi_mosi, spi_cs_n
  );
endinterface

// File: rtl/spi_bus_arbiter.sv
// Round-robin owner of the board SPI bus: grants one requester, drives its
// chip select and runs a single mode-0, MSB-first transfer of DATA_W bits.
module spi_bus_arbiter #(
  parameter int NUM_REQ  = 4,
  parameter int DATA_W   = 16,
  parameter int CLK_DIV  = 4,
  parameter int CS_SETUP = 2,
  parameter int CS_HOLD  = 2,
  parameter int CS_GAP   = 2
) (
  input  logic                clk,
  input  logic                rst,
  spi_bus_arbiter_if.master   bus_io
);

  localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int BIT_W = $clog2(DATA_W);
  localparam int CNT_W = 16;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_SHIFT = 3'd2,
    S_HOLD  = 3'd3,
    S_GAP   = 3'd4
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [BIT_W-1:0]    bit_q, bit_d;
  logic [IDX_W-1:0]    rr_q, rr_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d;
  logic [NUM_REQ-1:0]  done_q, done_d;
  logic [NUM_REQ-1:0]  cs_n_q, cs_n_d;
  logic                sclk_q, sclk_d;
  logic                mosi_q, mosi_d;
  logic                busy_q, busy_d;
  logic [DATA_W-1:0]   tx_sh_q, tx_sh_d;
  logic [DATA_W-1:0]   rx_sh_q, rx_sh_d;
  logic [DATA_W-1:0]   rx_q, rx_d;

  int                  cand_s;
  logic [IDX_W-1:0]    cand_idx_s;
  logic                win_found_s;
  logic [IDX_W-1:0]    win_idx_s;
  logic [NUM_REQ-1:0]  win_onehot_s;
  logic [DATA_W-1:0]   tx_sel_s;

  // Round-robin winner: first set req bit searching upward from rr_q.
  always_comb begin
    cand_s       = 0;
    cand_idx_s   = '0;
    win_found_s  = 1'b0;
    win_idx_s    = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand_s      = (int'(rr_q) + k) % NUM_REQ;
      cand_idx_s  = IDX_W'(cand_s);
      win_idx_s   = (bus_io.req[cand_idx_s] && !win_found_s) ? cand_idx_s : win_idx_s;
      win_found_s = win_found_s | bus_io.req[cand_idx_s];
    end
    win_onehot_s = NUM_REQ'(1) << win_idx_s;
    tx_sel_s     = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      tx_sel_s = (win_idx_s == IDX_W'(i)) ? bus_io.tx_data[i*DATA_W +: DATA_W] : tx_sel_s;
    end
  end

  // Next-state and next-output logic of the transfer sequencer.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    rr_d    = rr_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    cs_n_d  = cs_n_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    busy_d  = busy_q;
    tx_sh_d = tx_sh_q;
    rx_sh_d = rx_sh_q;
    rx_d    = rx_q;
    case (state_q)
      S_IDLE: begin
        if (win_found_s) begin
          state_d = S_SETUP;
          cnt_d   = '0;
          gnt_d   = win_onehot_s;
          cs_n_d  = ~win_onehot_s;
          busy_d  = 1'b1;
          tx_sh_d = tx_sel_s;
          mosi_d  = tx_sel_s[DATA_W-1];
          rr_d    = (win_idx_s == IDX_W'(NUM_REQ-1)) ? '0 : win_idx_s + IDX_W'(1);
        end else begin
          busy_d  = 1'b0;
        end
      end
      S_SETUP: begin
        if (cnt_q == CNT_W'(CS_SETUP-1)) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_SHIFT: begin
        // cnt_q walks one bit period: CLK_DIV low cycles, then CLK_DIV high.
        if (cnt_q == CNT_W'(2*CLK_DIV-1)) begin
          cnt_d  = '0;
          sclk_d = 1'b0;
          if (bit_q == BIT_W'(DATA_W-1)) begin
            state_d = S_HOLD;
          end else begin
            bit_d   = bit_q + BIT_W'(1);
            tx_sh_d = {tx_sh_q[DATA_W-2:0], 1'b0};
            mosi_d  = tx_sh_q[DATA_W-2];
          end
        end else if (cnt_q == CNT_W'(CLK_DIV-1)) begin
          cnt_d   = cnt_q + CNT_W'(1);
          sclk_d  = 1'b1;
          rx_sh_d = {rx_sh_q[DATA_W-2:0], bus_io.spi_miso};
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == CNT_W'(CS_HOLD-1)) begin
          state_d = S_GAP;
          cnt_d   = '0;
          cs_n_d  = '1;
          gnt_d   = '0;
          done_d  = gnt_q;
          rx_d    = rx_sh_q;
          mosi_d  = 1'b0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      S_GAP: begin
        if (cnt_q == CNT_W'(CS_GAP-1)) begin
          state_d = S_IDLE;
          cnt_d   = '0;
          busy_d  = 1'b0;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        gnt_d   = '0;
        cs_n_d  = '1;
        sclk_d  = 1'b0;
        mosi_d  = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and registered-output update; reset aborts any transfer silently.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      rr_q    <= '0;
      gnt_q   <= '0;
      done_q  <= '0;
      cs_n_q  <= '1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
      busy_q  <= 1'b0;
      tx_sh_q <= '0;
      rx_sh_q <= '0;
      rx_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      rr_q    <= rr_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      cs_n_q  <= cs_n_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
      busy_q  <= busy_d;
      tx_sh_q <= tx_sh_d;
      rx_sh_q <= rx_sh_d;
      rx_q    <= rx_d;
    end
  end

  assign bus_io.gnt      = gnt_q;
  assign bus_io.done     = done_q;
  assign bus_io.rx_data  = rx_q;
  assign bus_io.busy     = busy_q;
  assign bus_io.spi_sclk = sclk_q;
  assign bus_io.spi_mosi = mosi_q;
  assign bus_io.spi_cs_n = cs_n_q;

endmodule

// File: tb/tb_spi_bus_arbiter.sv
// Scoreboard bench for spi_bus_arbiter: default instance plus a
// minimum-parameter instance, with a mode-0 slave model on the bus.
module tb_spi_bus_arbiter;
  localparam int NR   = 4;
  localparam int DW   = 16;
  localparam int CD   = 4;
  localparam int SU   = 2;
  localparam int HO   = 2;
  localparam int GP   = 2;
  localparam int XFER = SU + 2*CD*DW + HO;
  localparam int DW2  = 8;
  localparam int XFER2 = 1 + 2*1*DW2 + 1;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  spi_bus_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW))  bus ();
  spi_bus_arbiter_if #(.NUM_REQ(NR), .DATA_W(DW2)) bus2 ();

  spi_bus_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .CLK_DIV(CD), .CS_SETUP(SU),
                    .CS_HOLD(HO), .CS_GAP(GP)) dut (
    .clk(clk), .rst(rst), .bus_io(bus));

  spi_bus_arbiter #(.NUM_REQ(NR), .DATA_W(DW2), .CLK_DIV(1), .CS_SETUP(1),
                    .CS_HOLD(1), .CS_GAP(1)) dut_min (
    .clk(clk), .rst(rst), .bus_io(bus2));

  typedef struct {
    int          idx;
    logic [31:0] tx;
    logic [31:0] rx;
  } exp_t;

  exp_t sb[$];
  exp_t sb2[$];

  logic [DW-1:0] slave_word [NR];
  logic [DW-1:0] cur_word;
  logic [DW-1:0] mosi_cap;
  logic [NR-1:0] exp_done;
  logic          miso_s;
  logic          prev_sclk;
  logic          prev_all_high;
  int            rise_cnt, cur_idx, cyc, fall_cyc, high_run;
  bit            had_xfer;
  exp_t          mon_e;

  assign bus.spi_miso = miso_s;

  // Slave model, invariant checks and scoreboard pop on every done pulse.
  always @(negedge clk) begin
    cyc++;
    checks++;
    if (!$onehot0(bus.gnt) || !$onehot0(~bus.spi_cs_n) || (bus.gnt !== ~bus.spi_cs_n) ||
        ((&bus.spi_cs_n) && (bus.spi_sclk !== 1'b0))) begin
      failures++;
      $display("FAIL invariant cyc=%0d gnt=%b cs_n=%b sclk=%b", cyc, bus.gnt, bus.spi_cs_n, bus.spi_sclk);
    end
    if (rst) begin
      rise_cnt = 0; had_xfer = 1'b0; high_run = 0;
      prev_sclk = 1'b0; prev_all_high = 1'b1; miso_s = 1'b0;
    end else begin
      if (prev_all_high && !(&bus.spi_cs_n)) begin
        for (int i = 0; i < NR; i++) if (!bus.spi_cs_n[i]) cur_idx = i;
        cur_word = slave_word[cur_idx];
        rise_cnt = 0; mosi_cap = '0; fall_cyc = cyc;
        if (had_xfer) begin
          checks++;
          if (high_run < GP) begin
            failures++;
            $display("FAIL cs_gap actual=%0d required>=%0d", high_run, GP);
          end
        end
      end
      if (&bus.spi_cs_n) high_run++; else high_run = 0;
      if (!(&bus.spi_cs_n) && bus.spi_sclk && !prev_sclk) begin
        mosi_cap = {mosi_cap[DW-2:0], bus.spi_mosi};
        rise_cnt++;
      end
      if (bus.done != '0) begin
        had_xfer = 1'b1;
        checks++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL unexpected_done actual=%b required=0000", bus.done);
        end else begin
          mon_e = sb.pop_front();
          exp_done = '0;
          exp_done[mon_e.idx] = 1'b1;
          if (bus.done !== exp_done) begin
            failures++;
            $display("FAIL done_onehot actual=%b required=%b", bus.done, exp_done);
          end
          checks++;
          if (bus.rx_data !== mon_e.rx[DW-1:0]) begin
            failures++;
            $display("FAIL rx_data req%0d actual=%h required=%h", mon_e.idx, bus.rx_data, mon_e.rx[DW-1:0]);
          end
          checks++;
          if (mosi_cap !== mon_e.tx[DW-1:0]) begin
            failures++;
            $display("FAIL mosi_word req%0d actual=%h required=%h", mon_e.idx, mosi_cap, mon_e.tx[DW-1:0]);
          end
          checks++;
          if (rise_cnt != DW) begin
            failures++;
            $display("FAIL sclk_rises req%0d actual=%0d required=%0d", mon_e.idx, rise_cnt, DW);
          end
          checks++;
          if ((cyc - fall_cyc) != XFER) begin
            failures++;
            $display("FAIL latency req%0d actual=%0d required=%0d", mon_e.idx, cyc - fall_cyc, XFER);
          end
        end
      end
      miso_s = (rise_cnt < DW) ? cur_word[DW-1-rise_cnt] : 1'b0;
      prev_sclk = bus.spi_sclk;
      prev_all_high = &bus.spi_cs_n;
    end
  end

  task automatic push(input int idx, input logic [DW-1:0] tx, input logic [DW-1:0] rx);
    exp_t e;
    bus.tx_data[idx*DW +: DW] = tx;
    slave_word[idx] = rx;
    e.idx = idx; e.tx = 32'(tx); e.rx = 32'(rx);
    sb.push_back(e);
  endtask

  task automatic wait_sb_size(input int n, input int budget, input string name);
    int t = 0;
    while (sb.size() > n && t < budget) begin @(negedge clk); t++; end
    checks++;
    if (sb.size() > n) begin
      failures++;
      $display("FAIL %s timeout pending=%0d required=%0d", name, sb.size(), n);
    end
  endtask

  task automatic wait_gnt(input int idx, input int budget, input string name);
    int t = 0;
    while (bus.gnt[idx] !== 1'b1 && t < budget) begin @(negedge clk); t++; end
    checks++;
    if (bus.gnt[idx] !== 1'b1) begin
      failures++;
      $display("FAIL %s grant timeout gnt=%b required_bit=%0d", name, bus.gnt, idx);
    end
  endtask

  task automatic wait_idle(input string name);
    int t = 0;
    while (bus.busy !== 1'b0 && t < 20) begin @(negedge clk); t++; end
    checks++;
    if (bus.busy !== 1'b0 || bus.gnt !== 4'b0000) begin
      failures++;
      $display("FAIL %s idle busy=%b gnt=%b required busy=0 gnt=0000", name, bus.busy, bus.gnt);
    end
  endtask

  task automatic test_reset();
    bus.req = '0; bus.tx_data = '0; bus2.req = '0; bus2.tx_data = '0; bus2.spi_miso = 1'b0;
    rst = 1'b0;
    #2 rst = 1'b1;
    repeat (3) @(negedge clk);
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL reset_gnt actual=%b required=0000", bus.gnt); end
    checks++; if (bus.done !== 4'b0000) begin failures++; $display("FAIL reset_done actual=%b required=0000", bus.done); end
    checks++; if (bus.rx_data !== 16'h0000) begin failures++; $display("FAIL reset_rx actual=%h required=0000", bus.rx_data); end
    checks++; if (bus.busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b required=0", bus.busy); end
    checks++; if (bus.spi_sclk !== 1'b0 || bus.spi_mosi !== 1'b0) begin failures++; $display("FAIL reset_pins sclk=%b mosi=%b required=0,0", bus.spi_sclk, bus.spi_mosi); end
    checks++; if (bus.spi_cs_n !== 4'b1111) begin failures++; $display("FAIL reset_cs_n actual=%b required=1111", bus.spi_cs_n); end
    checks++; if (bus2.spi_cs_n !== 4'b1111) begin failures++; $display("FAIL reset_cs_n_min actual=%b required=1111", bus2.spi_cs_n); end
    rst = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_single();
    push(2, 16'hA5C3, 16'h3C5A);
    bus.req = 4'b0100;
    wait_sb_size(0, XFER + 20, "single");
    bus.req = '0;
    wait_idle("single");
  endtask

  task automatic test_all();
    rst = 1'b1;
    bus.req = 4'b1111;
    push(0, 16'h1357, 16'hFACE);
    push(1, 16'h2468, 16'h0F0F);
    push(2, 16'hDEAD, 16'h8001);
    push(3, 16'hBEEF, 16'h7FFE);
    push(0, 16'h1357, 16'hFACE);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    wait_sb_size(0, 5*(XFER + 10), "all_order");
    bus.req = '0;
    wait_idle("all_order");
  endtask

  task automatic test_round_robin();
    push(1, 16'h0001, 16'hC001);
    bus.req = 4'b0010;
    wait_gnt(1, 10, "rr_first");
    push(0, 16'h8000, 16'h5AA5);
    bus.req = 4'b0011;
    wait_sb_size(1, XFER + 20, "rr_first_done");
    bus.req = 4'b0001;
    wait_sb_size(0, XFER + 20, "rr_second_done");
    bus.req = '0;
    wait_idle("rr");
  endtask

  task automatic test_req_drop();
    push(3, 16'h6B2D, 16'h9249);
    bus.req = 4'b1000;
    wait_gnt(3, 10, "drop");
    repeat (SU + 10) @(negedge clk);
    bus.req = '0;
    wait_sb_size(0, XFER + 20, "drop_done");
    wait_idle("drop");
  endtask

  task automatic test_reset_mid();
    slave_word[2] = 16'hFFFF;
    bus.req = 4'b0100;
    wait_gnt(2, 10, "rst_mid");
    repeat (SU + 40) @(negedge clk);
    bus.req = '0;
    rst = 1'b1;
    #1;
    checks++; if (bus.spi_cs_n !== 4'b1111) begin failures++; $display("FAIL rst_mid_cs_n actual=%b required=1111", bus.spi_cs_n); end
    checks++; if (bus.spi_sclk !== 1'b0) begin failures++; $display("FAIL rst_mid_sclk actual=%b required=0", bus.spi_sclk); end
    checks++; if (bus.gnt !== 4'b0000) begin failures++; $display("FAIL rst_mid_gnt actual=%b required=0000", bus.gnt); end
    checks++; if (bus.done !== 4'b0000) begin failures++; $display("FAIL rst_mid_done actual=%b required=0000", bus.done); end
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push(0, 16'h0FF0, 16'hA55A);
    bus.req = 4'b0001;
    wait_sb_size(0, XFER + 20, "rst_mid_after");
    bus.req = '0;
    wait_idle("rst_mid_after");
  endtask

  task automatic test_min_params();
    exp_t e, got_e;
    int n = 0, fall_n = -1, last_rise = -1, rises = 0;
    logic [DW2-1:0] cap = '0;
    logic p_sclk = 1'b0;
    bit got = 1'b0;
    e.idx = 0; e.tx = 32'h0000_0081; e.rx = 32'h0000_00FF;
    sb2.push_back(e);
    bus2.tx_data[DW2-1:0] = 8'h81;
    bus2.spi_miso = 1'b1;
    bus2.req = 4'b0001;
    while (!got && n < 80) begin
      @(negedge clk);
      if (fall_n < 0 && bus2.spi_cs_n[0] === 1'b0) fall_n = n;
      if (bus2.spi_cs_n[0] === 1'b0 && bus2.spi_sclk && !p_sclk) begin
        if (last_rise >= 0) begin
          checks++;
          if (n - last_rise != 2) begin
            failures++;
            $display("FAIL min_sclk_period actual=%0d required=2", n - last_rise);
          end
        end
        last_rise = n;
        rises++;
        cap = {cap[DW2-2:0], bus2.spi_mosi};
      end
      p_sclk = bus2.spi_sclk;
      if (bus2.done[0] === 1'b1) begin
        got = 1'b1;
        bus2.req = '0;
        got_e = sb2.pop_front();
        checks++;
        if (n - fall_n != XFER2) begin failures++; $display("FAIL min_latency actual=%0d required=%0d", n - fall_n, XFER2); end
        checks++;
        if (bus2.rx_data !== got_e.rx[DW2-1:0]) begin failures++; $display("FAIL min_rx actual=%h required=%h", bus2.rx_data, got_e.rx[DW2-1:0]); end
        checks++;
        if (cap !== got_e.tx[DW2-1:0]) begin failures++; $display("FAIL min_mosi actual=%h required=%h", cap, got_e.tx[DW2-1:0]); end
        checks++;
        if (rises != DW2) begin failures++; $display("FAIL min_rises actual=%0d required=%0d", rises, DW2); end
      end
      n++;
    end
    checks++;
    if (!got) begin
      failures++;
      $display("FAIL min_done timeout cycles=%0d required<=%0d", n, 80);
    end
    bus2.req = '0;
    repeat (4) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_single();
    test_all();
    test_round_robin();
    test_req_drop();
    test_reset_mid();
    test_min_params();
    repeat (5) @(negedge clk);
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL leftover_expectations actual=%0d required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog time=%0t required=finish_before_limit", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
